fifo_rd_ctrl: RTL and testbench

Read-side controller for the single-clock FIFO. It owns the read pointer, drives the read address of the `fifo_mem` storage array, and samples that array's combinational read data. It presents entries on a registered first-word-fall-through valid/ready output. It pairs with the write-side controller, which owns `wptr`, and sits between `fifo_mem` and the downstream consumer.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_rd_ctrl.sv | 67 ++++++
 tb/tb_fifo_rd_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer type and occupancy helper used by both
// the read-side and write-side controllers.
package fifo_pkg;

  localparam int FIFO_AWIDTH = 4;
  localparam int FIFO_DWIDTH = 8;

  // Pointer carries one extra wrap bit so full and empty are distinguishable.
  typedef logic [FIFO_AWIDTH:0] ptr_t;

  function automatic ptr_t ptr_diff(input ptr_t head, input ptr_t tail);
    return head - tail;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: owns the read pointer and a registered
// first-word-fall-through output stage fed from the storage array.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DWIDTH = FIFO_DWIDTH,
  parameter int AWIDTH = FIFO_AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH:0]   wptr,
  input  logic [DWIDTH-1:0] rdata,
  output logic [AWIDTH-1:0] raddr,
  output logic [AWIDTH:0]   rptr,
  output logic              empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  input  logic              flush,
  output logic [AWIDTH:0]   level
);

  logic [AWIDTH:0] occ;
  logic            load;

  // Occupancy uses the shared helper when the widths line up with the package type.
  generate
    if (AWIDTH == FIFO_AWIDTH) begin : g_pkg_diff
      assign occ = ptr_diff(wptr, rptr);
    end else begin : g_local_diff
      assign occ = wptr - rptr;
    end
  endgenerate

  // Status and load decision, derived from the registered pointers.
  always_comb begin
    raddr = rptr[AWIDTH-1:0];
    empty = (wptr == rptr);
    level = occ + {{AWIDTH{1'b0}}, m_valid};
    load  = 1'b0;
    if (!empty && (!m_valid || m_ready)) begin
      load = 1'b1;
    end else begin
      load = 1'b0;
    end
  end

  // Pointer and output register; flush outranks any load or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr    <= {(AWIDTH + 1){1'b0}};
      m_valid <= 1'b0;
      m_data  <= {DWIDTH{1'b0}};
    end else if (flush) begin
      rptr    <= wptr;
      m_valid <= 1'b0;
    end else if (load) begin
      rptr    <= rptr + {{AWIDTH{1'b0}}, 1'b1};
      m_valid <= 1'b1;
      m_data  <= rdata;
    end else if (m_ready) begin
      // Consumer drained the last entry with nothing behind it; data is kept.
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl with a behavioural writer and storage array.
module tb_fifo_rd_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] wptr;
  logic [7:0] rdata;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       empty;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       flush;
  logic [4:0] level;

  logic       wr_en;
  logic [7:0] wdata;
  logic [7:0] mem [16];

  logic [7:0] sb [$];
  int         n_checks;
  int         n_fail;
  logic       prev_stall;
  logic [7:0] prev_data;

  fifo_rd_ctrl #(.DWIDTH(8), .AWIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wptr    (wptr),
    .rdata   (rdata),
    .raddr   (raddr),
    .rptr    (rptr),
    .empty   (empty),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .flush   (flush),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdata = mem[raddr];

  // Behavioural write-side controller and storage array.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 5'd0;
    end else if (wr_en) begin
      mem[wptr[3:0]] <= wdata;
      wptr           <= wptr + 5'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops on every transfer and checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          check("data_order", {24'd0, m_data}, {24'd0, sb.pop_front()});
        end
      end
      prev_stall = m_valid && !m_ready && !flush;
      prev_data  = m_data;
    end
  end

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wdata = d;
    sb.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 300 && (sb.size() != 0 || m_valid); i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_done", {31'd0, (sb.size() == 0 && !m_valid)}, 32'd1);
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_rptr", {27'd0, rptr}, {27'd0, wptr});
    check("drain_level", {27'd0, level}, 32'd0);
  endtask

  initial begin
    logic [4:0] base;
    int         sent;
    n_checks   = 0;
    n_fail     = 0;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    rst_n   = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b0;
    wdata   = 8'd0;

    // Reset state
    #12;
    check("rst_rptr", {27'd0, rptr}, 32'd0);
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_data", {24'd0, m_data}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_level", {27'd0, level}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);

    // Single entry with a stalled consumer
    wr(8'hA5);
    check("single_pre_valid", {31'd0, m_valid}, 32'd0);
    check("single_pre_empty", {31'd0, empty}, 32'd0);
    tick(1);
    check("single_valid", {31'd0, m_valid}, 32'd1);
    check("single_data", {24'd0, m_data}, 32'h0000_00A5);
    check("single_rptr", {27'd0, rptr}, 32'd1);
    check("single_level", {27'd0, level}, 32'd1);
    check("single_empty", {31'd0, empty}, 32'd1);
    tick(5);
    check("single_hold", {24'd0, m_data}, 32'h0000_00A5);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    check("single_popped", {31'd0, m_valid}, 32'd0);
    check("single_level0", {27'd0, level}, 32'd0);

    // Streaming at full rate
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) wr(8'(i));
    drain();
    check("stream_rptr", {27'd0, rptr}, 32'd21);

    // Full: array holds 16 plus the output register
    m_ready = 1'b0;
    base = wptr;
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i));
    check("full_valid", {31'd0, m_valid}, 32'd1);
    check("full_level16", {27'd0, level}, 32'd16);
    wr(8'h50);
    check("full_level17", {27'd0, level}, 32'd17);
    check("full_rptr", {27'd0, rptr}, {27'd0, base + 5'd1});
    check("full_not_empty", {31'd0, empty}, 32'd0);
    drain();

    // Random backpressure over 100 entries
    sent = 0;
    for (int cyc = 0; cyc < 2000 && sent < 100; cyc++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (5'(wptr - rptr) < 5'd16 && $urandom_range(0, 2) != 0) begin
        wr_en = 1'b1;
        wdata = 8'($urandom);
        sb.push_back(wdata);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
    end
    check("random_sent", sent, 32'd100);
    drain();

    // Flush coincident with a write
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i));
    check("flush_level6", {27'd0, level}, 32'd6);
    flush = 1'b1;
    wr_en = 1'b1;
    wdata = 8'h77;
    sb.delete();
    sb.push_back(8'h77);
    @(posedge clk);
    #1;
    flush = 1'b0;
    wr_en = 1'b0;
    check("flush_valid0", {31'd0, m_valid}, 32'd0);
    check("flush_level1", {27'd0, level}, 32'd1);
    tick(1);
    check("flush_valid1", {31'd0, m_valid}, 32'd1);
    check("flush_data", {24'd0, m_data}, 32'h0000_0077);
    check("flush_level", {27'd0, level}, 32'd1);
    drain();

    // Asynchronous reset mid-transfer
    m_ready = 1'b1;
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, m_valid}, 32'd0);
    check("arst_rptr", {27'd0, rptr}, 32'd0);
    check("arst_data", {24'd0, m_data}, 32'd0);
    check("arst_empty", {31'd0, empty}, 32'd1);
    check("arst_level", {27'd0, level}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    check("post_rst_valid", {31'd0, m_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
